parking_lot_multi_lane_counter: RTL and testbench
=================================================

Name: parking_lot_multi_lane_counter

Overview:
- Parametrised multi-lane occupancy counter for a parking lot with NUM_LANES gates.
- Each gate has a two-sensor pair (a = outer, b = inner) and its own direction-decoding FSM that emits one-cycle enter/exit events.
- Events from all lanes in a cycle are summed into one saturating occupancy count with full/empty flags.
- Sits between the per-sensor debouncers and the display/binary-to-decimal path. Inputs are debounced, synchronous levels.

Parameters:
- NUM_LANES, 2: number of gates, 1..8.
- CAPACITY, 9999: maximum occupancy; count saturates here.
- COUNT_W, 14: width of count_o; must satisfy 2**COUNT_W > CAPACITY.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear of count and all lane FSMs.
- sensor_a_i  in  NUM_LANES  outer sensor per lane, 1 = blocked.
- sensor_b_i  in  NUM_LANES  inner sensor per lane, 1 = blocked.
- count_o  out  COUNT_W  current occupancy.
- full_o  out  1  count_o == CAPACITY.
- empty_o  out  1  count_o == 0.
- enter_pulse_o  out  NUM_LANES  one-cycle pulse per completed entry.
- exit_pulse_o  out  NUM_LANES  one-cycle pulse per completed exit.
- sat_o  out  1  one-cycle pulse when a clamp occurred at the last count update.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni. All state is reset asynchronously when rst_ni = 0.
- Reset values: count_o = 0, empty_o = 1, full_o = 0, all pulses = 0, sat_o = 0, every lane FSM in IDLE.
- Per-lane FSM: evaluates the sampled pair ab each cycle.
  - IDLE: 10 -> ENTER_0; 01 -> EXIT_0; 00 or 11 -> stay (11 from idle is ambiguous and ignored).
  - ENTER_0: 10 stay; 11 -> ENTER_1; 00 or 01 -> IDLE (abort).
  - ENTER_1: 11 stay; 10 -> ENTER_0; 01 -> ENTER_2; 00 -> IDLE.
  - ENTER_2: 01 stay; 11 -> ENTER_1; 00 -> IDLE and register an enter event; 10 -> IDLE (abort).
  - EXIT_0/1/2: mirror of ENTER with a and b swapped. Leaving EXIT_2 on 00 registers an exit event.
  - Illegal state encoding -> IDLE.
- Event pulse timing: enter_pulse_o[i] / exit_pulse_o[i] is high for exactly one cycle, starting at the edge where the FSM leaves ENTER_2/EXIT_2 on 00.
- Count update: occurs on the edge after the pulse, so count latency is 2 cycles from the clock edge sampling 00.
  - E = popcount(enter_pulse_o), X = popcount(exit_pulse_o).
  - next = count_o + E − X, evaluated signed in COUNT_W+2 bits.
  - next < 0 -> 0; next > CAPACITY -> CAPACITY. Either clamp asserts sat_o for that one update cycle.
- Simultaneous events: enters and exits on different lanes in the same cycle net out with no clamp. Example: count = CAPACITY with E = 1, X = 1 gives count unchanged and sat_o = 0.
- full_o / empty_o: registered alongside count_o and always consistent with it.
- clear_i: count_o = 0, all FSMs to IDLE, pulses dropped. clear_i has priority over any event in the same cycle.
- Reset mid-sequence: an FSM in any partial state returns to IDLE and the in-flight car is not counted.

Optional Feature:
- Macro: PARKING_SAT_STICKY_EN.
- Defined: sat_o is sticky. It sets on any clamp and holds until clear_i or reset.
- Undefined: sat_o is a one-cycle pulse as described under Behaviour.

Test Plan:
- Lane 0 sequence 00,10,11,01,00 (each held 3 cycles) -> enter_pulse_o[0] one cycle; count_o 0->1 two cycles after 00 sampled; empty_o 1->0.
- Lane 1 sequence 00,01,11,10,00 with count = 3 -> exit_pulse_o[1] one cycle; count_o = 2.
- Lane 0 sequence 10,11,10,00 (backs out) -> no pulse; count unchanged; FSM back to IDLE.
- CAPACITY = 5, count = 5; lane 0 enters and lane 1 exits in the same cycle -> count 5, sat_o = 0. Then lane 0 alone enters -> count 5, full_o = 1, sat_o pulse (sticky with PARKING_SAT_STICKY_EN).
- count = 0; exit completes -> count 0, sat_o pulse, empty_o stays 1.
- Lane 0 in ENTER_1; assert rst_ni = 0 (or clear_i = 1) for one cycle -> count_o = 0, all outputs at reset values; lane 0 resumes from IDLE and completing the pattern tail (01,00) yields no enter pulse.

Source files
------------

// File: rtl/parking_lot_multi_lane_counter.sv
// Multi-lane parking occupancy counter: per-gate direction FSMs feed one saturating count.
// Optional build macro PARKING_SAT_STICKY_EN makes sat_o hold until clear_i or reset.
module parking_lot_multi_lane_counter #(
    parameter int NUM_LANES = 2,
    parameter int CAPACITY  = 9999,
    parameter int COUNT_W   = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [NUM_LANES-1:0] sensor_a_i,
    input  logic [NUM_LANES-1:0] sensor_b_i,
    output logic [COUNT_W-1:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [NUM_LANES-1:0] enter_pulse_o,
    output logic [NUM_LANES-1:0] exit_pulse_o,
    output logic                 sat_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER_0 = 3'd1,
        ENTER_1 = 3'd2,
        ENTER_2 = 3'd3,
        EXIT_0  = 3'd4,
        EXIT_1  = 3'd5,
        EXIT_2  = 3'd6
    } laneState_e;

    typedef logic signed [COUNT_W+1:0] wide_t;
    typedef logic [COUNT_W-1:0]        cnt_t;

    localparam wide_t CAP_W = wide_t'(CAPACITY);
    localparam cnt_t  CAP_C = cnt_t'(CAPACITY);

    laneState_e           laneState_q [NUM_LANES];
    laneState_e           laneState_d [NUM_LANES];
    logic [NUM_LANES-1:0] enterEvent_d, exitEvent_d;
    logic [NUM_LANES-1:0] enterPulse_q, exitPulse_q;

    cnt_t  count_q, count_d;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  sat_q, sat_d;
    wide_t enterSum, exitSum, sumW;
    logic  clampLow, clampHigh;

    // Exit states are the enter states with the roles of a and b swapped.
    function automatic laneState_e laneNext(input laneState_e s, input logic a, input logic b);
        laneState_e n;
        n = s;
        case (s)
            IDLE: begin
                case ({a, b})
                    2'b10:   n = ENTER_0;
                    2'b01:   n = EXIT_0;
                    default: n = IDLE;
                endcase
            end
            ENTER_0: begin
                case ({a, b})
                    2'b10:   n = ENTER_0;
                    2'b11:   n = ENTER_1;
                    default: n = IDLE;
                endcase
            end
            ENTER_1: begin
                case ({a, b})
                    2'b11:   n = ENTER_1;
                    2'b10:   n = ENTER_0;
                    2'b01:   n = ENTER_2;
                    default: n = IDLE;
                endcase
            end
            ENTER_2: begin
                case ({a, b})
                    2'b01:   n = ENTER_2;
                    2'b11:   n = ENTER_1;
                    default: n = IDLE;
                endcase
            end
            EXIT_0: begin
                case ({a, b})
                    2'b01:   n = EXIT_0;
                    2'b11:   n = EXIT_1;
                    default: n = IDLE;
                endcase
            end
            EXIT_1: begin
                case ({a, b})
                    2'b11:   n = EXIT_1;
                    2'b01:   n = EXIT_0;
                    2'b10:   n = EXIT_2;
                    default: n = IDLE;
                endcase
            end
            EXIT_2: begin
                case ({a, b})
                    2'b10:   n = EXIT_2;
                    2'b11:   n = EXIT_1;
                    default: n = IDLE;
                endcase
            end
            default: n = IDLE;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                laneState_q[i] <= IDLE;
            end
            enterPulse_q <= '0;
            exitPulse_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                laneState_q[i] <= laneState_d[i];
            end
            enterPulse_q <= enterEvent_d;
            exitPulse_q  <= exitEvent_d;
        end
    end

    // A car is only counted when the pair fully clears from the far-side state.
    always_comb begin
        enterEvent_d = '0;
        exitEvent_d  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            laneState_d[i] = laneNext(laneState_q[i], sensor_a_i[i], sensor_b_i[i]);
            enterEvent_d[i] = (laneState_q[i] == ENTER_2) && !sensor_a_i[i] && !sensor_b_i[i];
            exitEvent_d[i]  = (laneState_q[i] == EXIT_2)  && !sensor_a_i[i] && !sensor_b_i[i];
            if (clear_i) begin
                laneState_d[i]  = IDLE;
                enterEvent_d[i] = 1'b0;
                exitEvent_d[i]  = 1'b0;
            end
        end
    end

    // Net all lanes first so simultaneous enters and exits cancel before any clamp.
    always_comb begin
        enterSum = '0;
        exitSum  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            enterSum = enterSum + wide_t'(enterPulse_q[i]);
            exitSum  = exitSum  + wide_t'(exitPulse_q[i]);
        end
        sumW      = wide_t'(count_q) + enterSum - exitSum;
        clampLow  = sumW < wide_t'(0);
        clampHigh = sumW > CAP_W;

        if (clampLow) begin
            count_d = '0;
        end else if (clampHigh) begin
            count_d = CAP_C;
        end else begin
            count_d = sumW[COUNT_W-1:0];
        end

`ifdef PARKING_SAT_STICKY_EN
        sat_d = sat_q | clampLow | clampHigh;
`else
        sat_d = clampLow | clampHigh;
`endif

        if (clear_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end
        full_d  = (count_d == CAP_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o       = count_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign sat_o         = sat_q;
    assign enter_pulse_o = enterPulse_q;
    assign exit_pulse_o  = exitPulse_q;

endmodule

// File: tb/tb_parking_lot_multi_lane_counter.sv
// Bench for parking_lot_multi_lane_counter: two lanes, capacity 5, table vectors plus reset/clear sequences.
// Handles both builds of PARKING_SAT_STICKY_EN.
module tb_parking_lot_multi_lane_counter;

    localparam int LANES = 2;
    localparam int CAP   = 5;
    localparam int CW    = 14;
`ifdef PARKING_SAT_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic             clk_i   = 1'b0;
    logic             rst_ni  = 1'b0;
    logic             clear_i = 1'b0;
    logic [LANES-1:0] sensorA = '0;
    logic [LANES-1:0] sensorB = '0;
    logic [CW-1:0]    count;
    logic             full, empty, sat;
    logic [LANES-1:0] enterPulse, exitPulse;

    parking_lot_multi_lane_counter #(
        .NUM_LANES(LANES),
        .CAPACITY (CAP),
        .COUNT_W  (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .sensor_a_i   (sensorA),
        .sensor_b_i   (sensorB),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .enter_pulse_o(enterPulse),
        .exit_pulse_o (exitPulse),
        .sat_o        (sat)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] en;
        logic [1:0] ex;
        int         cnt;
        logic       full;
        logic       empty;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       clr;
        int         reps;
        exp_t       e;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   stepIdx = 0;

    function automatic exp_t mkExp(input logic [1:0] en, input logic [1:0] ex, input int cnt, input logic s);
        exp_t e;
        e.en    = en;
        e.ex    = ex;
        e.cnt   = cnt;
        e.full  = (cnt == CAP);
        e.empty = (cnt == 0);
        e.sat   = s;
        return e;
    endfunction

    function automatic vec_t mkVec(input logic [1:0] a, input logic [1:0] b, input logic clr, input int reps,
                                   input logic [1:0] en, input logic [1:0] ex, input int cnt, input logic s);
        vec_t v;
        v.a    = a;
        v.b    = b;
        v.clr  = clr;
        v.reps = reps;
        v.e    = mkExp(en, ex, cnt, s);
        return v;
    endfunction

    task automatic cmpVal(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s step=%0d got=%0d want=%0d", nm, stepIdx, act, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        stepIdx++;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard step=%0d got=empty-queue want=entry", stepIdx);
        end else begin
            e = expQ.pop_front();
            cmpVal("enter_pulse", int'(enterPulse), int'(e.en));
            cmpVal("exit_pulse",  int'(exitPulse),  int'(e.ex));
            cmpVal("count",       int'(count),      e.cnt);
            cmpVal("full",        int'(full),       int'(e.full));
            cmpVal("empty",       int'(empty),      int'(e.empty));
            cmpVal("sat",         int'(sat),        int'(e.sat));
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic clr, input exp_t e);
        @(negedge clk_i);
        sensorA = a;
        sensorB = b;
        clear_i = clr;
        expQ.push_back(e);
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    task automatic checkNow(input exp_t e);
        expQ.push_back(e);
        checkOutput();
    endtask

    // Lane 0 one-cycle-per-step entry; count bumps on the cycle after the pulse.
    task automatic runEnter(input int cnt);
        applyStimulus(2'b01, 2'b00, 1'b0, mkExp(2'b00, 2'b00, cnt, 1'b0));
        applyStimulus(2'b01, 2'b01, 1'b0, mkExp(2'b00, 2'b00, cnt, 1'b0));
        applyStimulus(2'b00, 2'b01, 1'b0, mkExp(2'b00, 2'b00, cnt, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b01, 2'b00, cnt, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b00, 2'b00, cnt + 1, 1'b0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // a/b bit 0 = lane 0, bit 1 = lane 1
        // lane 0 slow entry, each pattern held 3 cycles
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 3, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 3, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 3, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 3, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 2, 2'b00, 2'b00, 1, 0));
        // two fast back-to-back entries -> 3
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 1, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 3, 2'b00, 2'b00, 3, 0));
        // lane 1 slow exit -> 2
        vecs.push_back(mkVec(2'b00, 2'b10, 0, 3, 2'b00, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b10, 2'b10, 0, 3, 2'b00, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b10, 2'b00, 0, 3, 2'b00, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 3, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 2, 2'b00, 2'b00, 2, 0));
        // lane 0 backs out: no pulse
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 2, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 2, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 2, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 3, 2'b00, 2'b00, 2, 0));
        // both lanes enter together (+2), then lane 0 alone -> 5 (full)
        vecs.push_back(mkVec(2'b11, 2'b00, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b11, 2'b11, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b11, 0, 1, 2'b00, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b11, 2'b00, 2, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 4, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 4, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 4, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 4, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 5, 0));
        // at capacity: lane 0 enters while lane 1 exits -> no clamp
        vecs.push_back(mkVec(2'b01, 2'b10, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b11, 2'b11, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b10, 2'b01, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b10, 5, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 5, 0));
        // lane 0 alone at capacity -> clamp
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 5, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 5, 1));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 5, STICKY));
        vecs.push_back(mkVec(2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0));
        // clear wins over a pending count update
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b01, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
        // clear on the completing edge drops the pulse
        vecs.push_back(mkVec(2'b01, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
        // exit from empty -> underflow clamp
        vecs.push_back(mkVec(2'b00, 2'b10, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b10, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, STICKY));
        vecs.push_back(mkVec(2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0));
        // 11 straight from idle is ignored, so the 01,00 tail is an aborted exit
        vecs.push_back(mkVec(2'b01, 2'b01, 0, 2, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b01, 0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 0, 2, 2'b00, 2'b00, 0, 0));

        #12;
        checkNow(mkExp(2'b00, 2'b00, 0, 1'b0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                applyStimulus(vecs[k].a, vecs[k].b, vecs[k].clr, vecs[k].e);
            end
        end

        // async reset while lane 0 sits in ENTER_1
        runEnter(0);
        applyStimulus(2'b01, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 1, 1'b0));
        applyStimulus(2'b01, 2'b01, 1'b0, mkExp(2'b00, 2'b00, 1, 1'b0));
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkNow(mkExp(2'b00, 2'b00, 0, 1'b0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(2'b00, 2'b01, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));

        // synchronous clear while lane 0 sits in ENTER_1
        runEnter(0);
        applyStimulus(2'b01, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 1, 1'b0));
        applyStimulus(2'b01, 2'b01, 1'b0, mkExp(2'b00, 2'b00, 1, 1'b0));
        applyStimulus(2'b01, 2'b01, 1'b1, mkExp(2'b00, 2'b00, 0, 1'b0));
        applyStimulus(2'b00, 2'b01, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));
        applyStimulus(2'b00, 2'b00, 1'b0, mkExp(2'b00, 2'b00, 0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
